// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign fix-up and a 2*WIDTH result landing in the HI/LO registers.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

   state_t             state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] acc;
   logic               res_neg;
   logic               rem_neg;
   logic               zero_div;
   logic [CW-1:0]      cnt;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_rsh;
   logic [WIDTH:0]     div_diff;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic is_signed);
      if (is_signed && v < 0) return $unsigned(-v);
      return $unsigned(v);
   endfunction

   function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   // Multiply: upper half accumulates, lower half receives product bits as the sum shifts right.
   // Divide: dividend bits enter the partial remainder MSB first; quotient bits fill the lower half.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_mag[0] ? a_mag : {WIDTH{1'b0}})};
      div_rsh  = {acc[2*WIDTH-1:WIDTH], a_mag[WIDTH-1]};
      div_diff = div_rsh - {1'b0, b_mag};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         op_q        <= 2'b00;
         a_mag       <= '0;
         b_mag       <= '0;
         acc         <= '0;
         res_neg     <= 1'b0;
         rem_neg     <= 1'b0;
         zero_div    <= 1'b0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         case (state)
            IDLE: begin
               done        <= 1'b0;
               div_by_zero <= 1'b0;
               if (start) begin
                  op_q     <= op;
                  a_mag    <= magnitude(rs_data, ~op[0]);
                  b_mag    <= magnitude(rt_data, ~op[0]);
                  res_neg  <= ~op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  rem_neg  <= ~op[0] & rs_data[WIDTH-1];
                  zero_div <= op[1] & (rt_data == '0);
                  acc      <= '0;
                  cnt      <= CW'(WIDTH);
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            RUN: begin
               if (op_q[1]) begin
                  if (!div_diff[WIDTH])
                     acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  else
                     acc <= {div_rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                  a_mag <= a_mag << 1;
               end else begin
                  acc   <= {mul_sum, acc[WIDTH-1:1]};
                  b_mag <= b_mag >> 1;
               end
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               if (op_q[1]) begin
                  acc <= {(rem_neg ? negate_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH]),
                          (res_neg ? negate_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0])};
               end else if (res_neg) begin
                  acc <= negate_2w(acc);
               end
               state <= FIN;
            end
            FIN: begin
               if (!zero_div) begin
                  hi <= acc[2*WIDTH-1:WIDTH];
                  lo <= acc[WIDTH-1:0];
               end
               done        <= 1'b1;
               div_by_zero <= zero_div;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed scenarios plus randomized operations checked against
// a plain-arithmetic reference model of HI/LO.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  rs_data;
   logic [W-1:0]  rt_data;
   logic          hi_we;
   logic          lo_we;
   logic [W-1:0]  wdata;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int            checks;
   int            errors;
   logic [W-1:0]  exp_hi;
   logic [W-1:0]  exp_lo;
   logic          exp_dz;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: HI/LO after an operation, computed with ordinary 64-bit arithmetic.
   task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exp_dz = 1'b0;
      case (o)
         2'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
         2'd1: begin p = {32'h0, a} * {32'h0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
         2'd2: begin
            if (b == 0) exp_dz = 1'b1;
            else begin
               q = sa / sb; r = sa % sb;
               p = 64'(q); exp_lo = p[31:0];
               p = 64'(r); exp_hi = p[31:0];
            end
         end
         default: begin
            if (b == 0) exp_dz = 1'b1;
            else begin exp_lo = a / b; exp_hi = a % b; end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from idle and waits (bounded) for done.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt, output logic busy_d, output logic dz_d);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      tick();
      start = 1'b0; rs_data = $urandom; rt_data = $urandom;
      lat = 0; bcnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         tick();
         lat++;
      end
      busy_d = busy;
      dz_d   = div_by_zero;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (3) tick();
      #2 reset_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_multu_max();
      int lat, bcnt; logic bd, dz;
      do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, bd, dz);
      checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
      checks++; if (bcnt !== 34) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 34", bcnt); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b expected 0", bd); end
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
      exp_hi = hi; exp_lo = lo;
   endtask

   task automatic test_signed();
      int lat, bcnt; logic bd, dz;
      do_op(2'd0, 32'hFFFFFFFD, 32'd5, lat, bcnt, bd, dz);
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
      do_op(2'd2, 32'hFFFFFFF9, 32'd2, lat, bcnt, bd, dz);
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
      do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, bd, dz);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_ovf_flag: got %b expected 0", dz); end
      exp_hi = hi; exp_lo = lo;
   endtask

   task automatic test_mthi_mtlo();
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A55A5A;
      tick();
      hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (hi !== 32'hA5A55A5A) begin errors++; $display("FAIL mt_both_hi: got %h expected a5a55a5a", hi); end
      checks++; if (lo !== 32'hA5A55A5A) begin errors++; $display("FAIL mt_both_lo: got %h expected a5a55a5a", lo); end
      exp_hi = 32'hA5A55A5A; exp_lo = 32'hA5A55A5A;
   endtask

   task automatic test_div_zero();
      int lat, bcnt; logic bd, dz;
      hi_we = 1'b1; wdata = 32'hCAFEBABE; tick(); hi_we = 1'b0;
      lo_we = 1'b1; wdata = 32'h12345678; tick(); lo_we = 1'b0;
      do_op(2'd3, 32'd100, 32'd0, lat, bcnt, bd, dz);
      checks++; if (lat !== 34) begin errors++; $display("FAIL dz_latency: got %0d expected 34", lat); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz); end
      checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL dz_lo: got %h expected 12345678", lo); end
      checks++; if (hi !== 32'hCAFEBABE) begin errors++; $display("FAIL dz_hi: got %h expected cafebabe", hi); end
      tick();
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse: got %b expected 0", div_by_zero); end
      exp_hi = 32'hCAFEBABE; exp_lo = 32'h12345678;
   endtask

   task automatic test_start_ignored();
      int n;
      start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
      tick();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (n == 9) begin start = 1'b1; op = 2'd1; rs_data = 32'd2; rt_data = 32'd2; end
         else start = 1'b0;
         tick();
         n++;
      end
      start = 1'b0;
      checks++; if (n !== 34) begin errors++; $display("FAIL ign_latency: got %0d expected 34", n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_fall: got %b expected 0", busy); end
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ign_lo: got %h expected 0000000e", lo); end
      checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ign_hi: got %h expected 00000002", hi); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue: got busy %b expected 0", busy); end
      exp_hi = 32'd2; exp_lo = 32'd14;
   endtask

   task automatic test_start_beats_we();
      int n;
      hi_we = 1'b1; wdata = 32'h11111111; tick(); hi_we = 1'b0;
      start = 1'b1; op = 2'd1; rs_data = 32'd3; rt_data = 32'd4; hi_we = 1'b1; wdata = 32'hDEADBEEF;
      tick();
      start = 1'b0; hi_we = 1'b0;
      checks++; if (hi !== 32'h11111111) begin errors++; $display("FAIL sw_hi_kept: got %h expected 11111111", hi); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b expected 1", busy); end
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (n == 5) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55555555; end
         else begin hi_we = 1'b0; lo_we = 1'b0; end
         tick();
         n++;
      end
      hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL sw_final_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'd12) begin errors++; $display("FAIL sw_final_lo: got %h expected 0000000c", lo); end
      exp_hi = 32'h0; exp_lo = 32'd12;
   endtask

   task automatic test_back_to_back();
      int lat, bcnt; logic bd, dz;
      logic [1:0] o; logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'hFFFFFFFF;
            2: begin a = 32'h80000000; b = 32'($urandom_range(0, 15)); end
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         model(o, a, b);
         do_op(o, a, b, lat, bcnt, bd, dz);
         checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 34", i, lat); end
         checks++; if (hi !== exp_hi) begin errors++; $display("FAIL b2b_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, exp_hi); end
         checks++; if (lo !== exp_lo) begin errors++; $display("FAIL b2b_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, exp_lo); end
         checks++; if (dz !== exp_dz) begin errors++; $display("FAIL b2b_dz[%0d]: got %b expected %b", i, dz, exp_dz); end
      end
   endtask

   task automatic test_async_reset();
      int dones;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5; tick(); hi_we = 1'b0; lo_we = 1'b0;
      start = 1'b1; op = 2'd1; rs_data = 32'h0000FFFF; rt_data = 32'h0000FFFF;
      tick();
      start = 1'b0;
      repeat (15) tick();
      #2 reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", done); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL arst_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL arst_lo: got %h expected 0", lo); end
      repeat (2) tick();
      #2 reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL arst_no_done: got %0d pulses expected 0", dones); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL arst_lo_after: got %h expected 0", lo); end
      exp_hi = '0; exp_lo = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_multu_max();
      test_signed();
      test_mthi_mtlo();
      test_div_zero();
      test_start_ignored();
      test_start_beats_we();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
